sequenciador_notas: RTL and testbench
=====================================

# sequenciador_notas

Parametrised note recorder/player for the FPGAudio piano datapath. It samples an N-key keyboard on every metronome tick and run-length encodes the notes into an internal event buffer as (note, duration-in-ticks) pairs. It replays the buffer on demand, once or looped. It generalises the fixed 13-key, fixed-depth record path to configurable key count, depth and duration width, and adds looping, full detection and an end-of-playback pulse.

## Interface
- NUM_TECLAS, 13, number of keys; note code = key index+1, 0 = rest
- DEPTH, 256, event buffer entries; AW = $clog2(DEPTH)
- TEMPO_W, 4, duration field width; max duration DMAX = 2**TEMPO_W-1
- NOTA_W, $clog2(NUM_TECLAS+1), note code width
- clock  in  1  system clock; everything is on its rising edge
- reset  in  1  asynchronous, active-low
- tick  in  1  one-cycle metronome pulse; consecutive ticks are ≥3 cycles apart
- teclas  in  NUM_TECLAS  debounced keys; lowest asserted index wins
- grava  in  1  start-recording pulse
- toca  in  1  start-playback pulse
- para  in  1  stop pulse
- loop_en  in  1  playback wraps to entry 0 at end
- nota_out  out  NOTA_W  registered playback note; 0 outside TOCA
- nota_valida  out  1  high in TOCA when nota_out ≠ 0
- estado  out  2  IDLE=0, GRAVA=1, CARREGA=2, TOCA=3
- num_eventos  out  AW+1  stored event count
- cheio  out  1  num_eventos == DEPTH
- fim_reproducao  out  1  one-cycle end-of-playback pulse

## Operation
- Reset values: all outputs 0, estado IDLE, pending event cleared. Buffer contents are don't-care.
- IDLE, grava: num_eventos←0, pending←(current note, 0), go to GRAVA. If grava and toca arrive together, grava wins.
- IDLE, toca: if num_eventos=0, pulse fim_reproducao and stay in IDLE. Otherwise rd_addr←0 and go to CARREGA.
- GRAVA, tick with the same note as pending and dur<DMAX: dur+1.
- GRAVA, tick with a different note, or dur=DMAX: commit pending (if dur>0) at address num_eventos, num_eventos+1, pending←(note, 1).
- GRAVA, para: commit pending if dur>0, then go to IDLE. para has priority over a same-cycle tick; that tick is not counted.
- GRAVA, commit makes num_eventos reach DEPTH: cheio=1 and go to IDLE immediately. Further grava starts a fresh recording (count resets).
- CARREGA: synchronous buffer read, 1 cycle. Next state TOCA, with nota_out←stored note and rem←stored duration.
- TOCA, tick: rem-1. When rem reaches 0, move to the next entry:
  - rd_addr+1 < num_eventos: go to CARREGA with the next address.
  - last entry and loop active: rd_addr←0, go to CARREGA.
  - last entry otherwise: nota_out←0, pulse fim_reproducao, go to IDLE.
- TOCA, para: nota_out←0 and go to IDLE next cycle. No fim_reproducao pulse.
- grava/toca outside IDLE are ignored. The buffer is never written outside GRAVA.
- Duration 0 is never stored.

## Timing
- grava→estado=GRAVA: 1 cycle. The first tick is sampled after that.
- toca→first nota_out: 2 cycles (IDLE→CARREGA→TOCA).
- The tick ending entry k changes nota_out to entry k+1 2 cycles later.
- fim_reproducao is asserted on the cycle estado returns to IDLE.
- Commit write happens on the tick/para edge. num_eventos updates on the same edge.
- reset mid-operation aborts immediately, with no commit and no pulses.

## Configuration
- SEQUENCIADOR_LOOP_EN defined: loop_en is honoured as described.
- SEQUENCIADOR_LOOP_EN undefined: loop_en is ignored (treated 0), the port still exists, and playback always ends with fim_reproducao.

## Structure
- Package sequenciador_pkg: state enum (IDLE, GRAVA, CARREGA, TOCA) and the estado encodings.
- Sub-module memoria_eventos: DEPTH × (NOTA_W+TEMPO_W) single-port synchronous RAM with 1-cycle read latency.
- Key encoding and the FSM stay in the top module.

## Test plan
- Record: grava; key 2 held 3 ticks, key 5 held 2 ticks, para → num_eventos=2, entries (3,3), (6,2).
- Saturation, TEMPO_W=4: key 0 held 20 ticks, para → entries (1,15), (1,5).
- Playback: after the first test, toca → nota_out=3 for 3 ticks, then 6 for 2 ticks, then 0 with a single fim_reproducao pulse. First note appears 2 cycles after toca.
- Loop, SEQUENCIADOR_LOOP_EN defined, loop_en=1 → sequence 3,3,3,6,6,3,… and no fim_reproducao. Same test with the macro undefined → ends with the pulse.
- Full, DEPTH=4: alternate keys on every tick → after the 4th commit, cheio=1, estado=IDLE, further ticks ignored.
- Edge cases, each checked separately:
  - toca with an empty buffer → fim_reproducao pulse, stay in IDLE.
  - grava and toca together → GRAVA.
  - para in the same cycle as tick → tick not counted.
  - reset low mid-TOCA → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// Shared types for the note sequencer: FSM state encoding and width helpers.
// No latency, no flow control; pure declarations.
package sequenciador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRAVA   = 2'd1,
        CARREGA = 2'd2,
        TOCA    = 2'd3
    } estado_t;

    localparam logic [1:0] ESTADO_IDLE    = 2'd0;
    localparam logic [1:0] ESTADO_GRAVA   = 2'd1;
    localparam logic [1:0] ESTADO_CARREGA = 2'd2;
    localparam logic [1:0] ESTADO_TOCA    = 2'd3;

    function automatic int largura_nota(input int num_teclas);
        return $clog2(num_teclas + 1);
    endfunction

    function automatic int largura_end(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sequenciador_notas_if.sv
// Control/status bundle of the note sequencer; master drives keys and commands.
// Pulses are single-cycle, there is no backpressure on any signal.
interface sequenciador_notas_if #(
    parameter int NUM_TECLAS = 13,
    parameter int DEPTH      = 256,
    parameter int TEMPO_W    = 4
);
    import sequenciador_pkg::*;

    localparam int NOTA_W = largura_nota(NUM_TECLAS);
    localparam int AW     = largura_end(DEPTH);

    logic                  tick;
    logic [NUM_TECLAS-1:0] teclas;
    logic                  grava;
    logic                  toca;
    logic                  para;
    logic                  loop_en;
    logic [NOTA_W-1:0]     nota_out;
    logic                  nota_valida;
    logic [1:0]            estado;
    logic [AW:0]           num_eventos;
    logic                  cheio;
    logic                  fim_reproducao;

    modport master (
        output tick, teclas, grava, toca, para, loop_en,
        input  nota_out, nota_valida, estado, num_eventos, cheio, fim_reproducao
    );

    modport slave (
        input  tick, teclas, grava, toca, para, loop_en,
        output nota_out, nota_valida, estado, num_eventos, cheio, fim_reproducao
    );

endinterface

// File: rtl/sequenciador_notas_memoria.sv
// Event buffer: single-port synchronous RAM, write and read share one address.
// Read data appears one cycle after the address; no backpressure.
module memoria_eventos #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sequenciador_notas.sv
// Note recorder/player: run-length encodes keys per tick, replays on toca; loop honoured only with SEQUENCIADOR_LOOP_EN.
// toca->first note 2 cycles, entry change 2 cycles after the ending tick; commands outside IDLE are ignored.
module sequenciador_notas
    import sequenciador_pkg::*;
#(
    parameter int NUM_TECLAS = 13,
    parameter int DEPTH      = 256,
    parameter int TEMPO_W    = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    sequenciador_notas_if.slave   ctrl_if
);

    localparam int NOTA_W = largura_nota(NUM_TECLAS);
    localparam int AW     = largura_end(DEPTH);
    localparam int MW     = NOTA_W + TEMPO_W;

    localparam logic [TEMPO_W-1:0] DMAX     = '1;
    localparam logic [TEMPO_W-1:0] DUR_UM   = TEMPO_W'(1);
    localparam logic [AW:0]        NUM_UM   = (AW + 1)'(1);
    localparam logic [AW:0]        NUM_FULL = (AW + 1)'(DEPTH);

    estado_t             estado_q, estado_d;
    logic [AW:0]         num_q, num_d;
    logic [NOTA_W-1:0]   pend_nota_q, pend_nota_d;
    logic [TEMPO_W-1:0]  pend_dur_q, pend_dur_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [TEMPO_W-1:0]  rem_q, rem_d;
    logic [NOTA_W-1:0]   nota_q, nota_d;
    logic                fim_q, fim_d;

    logic [NOTA_W-1:0]   nota_atual;
    logic                loop_ativo;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [MW-1:0]       mem_wdata;
    logic [MW-1:0]       mem_rdata;
    logic [AW:0]         rd_prox;
    logic [AW:0]         num_inc;

`ifdef SEQUENCIADOR_LOOP_EN
    assign loop_ativo = ctrl_if.loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = ctrl_if.loop_en;
    assign loop_ativo     = 1'b0;
`endif

    // Descending scan so the lowest asserted key overrides higher ones.
    always_comb begin
        nota_atual = '0;
        for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
            if (ctrl_if.teclas[i]) begin
                nota_atual = NOTA_W'(i + 1);
            end
        end
    end

    assign rd_prox = {1'b0, rd_addr_q} + NUM_UM;
    assign num_inc = num_q + NUM_UM;

    always_comb begin
        estado_d    = estado_q;
        num_d       = num_q;
        pend_nota_d = pend_nota_q;
        pend_dur_d  = pend_dur_q;
        rd_addr_d   = rd_addr_q;
        rem_d       = rem_q;
        nota_d      = nota_q;
        fim_d       = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = {pend_nota_q, pend_dur_q};

        case (estado_q)
            IDLE: begin
                if (ctrl_if.grava) begin
                    num_d       = '0;
                    pend_nota_d = nota_atual;
                    pend_dur_d  = '0;
                    estado_d    = GRAVA;
                end else if (ctrl_if.toca) begin
                    if (num_q == '0) begin
                        fim_d = 1'b1;
                    end else begin
                        rd_addr_d = '0;
                        estado_d  = CARREGA;
                    end
                end
            end

            GRAVA: begin
                if (ctrl_if.para) begin
                    if (pend_dur_q != '0) begin
                        mem_we = 1'b1;
                        num_d  = num_inc;
                    end
                    estado_d = IDLE;
                end else if (ctrl_if.tick) begin
                    if (nota_atual == pend_nota_q && pend_dur_q != DMAX) begin
                        pend_dur_d = pend_dur_q + DUR_UM;
                    end else begin
                        if (pend_dur_q != '0) begin
                            mem_we = 1'b1;
                            num_d  = num_inc;
                            if (num_inc == NUM_FULL) begin
                                estado_d = IDLE;
                            end
                        end
                        pend_nota_d = nota_atual;
                        pend_dur_d  = DUR_UM;
                    end
                end
            end

            CARREGA: begin
                if (ctrl_if.para) begin
                    estado_d = IDLE;
                end else begin
                    nota_d   = mem_rdata[TEMPO_W +: NOTA_W];
                    rem_d    = mem_rdata[TEMPO_W-1:0];
                    estado_d = TOCA;
                end
            end

            TOCA: begin
                if (ctrl_if.para) begin
                    nota_d   = '0;
                    estado_d = IDLE;
                end else if (ctrl_if.tick) begin
                    if (rem_q > DUR_UM) begin
                        rem_d = rem_q - DUR_UM;
                    end else begin
                        rem_d  = '0;
                        nota_d = '0;
                        if (rd_prox < num_q) begin
                            rd_addr_d = rd_prox[AW-1:0];
                            estado_d  = CARREGA;
                        end else if (loop_ativo) begin
                            rd_addr_d = '0;
                            estado_d  = CARREGA;
                        end else begin
                            fim_d    = 1'b1;
                            estado_d = IDLE;
                        end
                    end
                end
            end

            default: estado_d = IDLE;
        endcase
    end

    // Reads use the next read address so data is ready during CARREGA.
    assign mem_addr = mem_we ? num_q[AW-1:0] : rd_addr_d;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            estado_q    <= IDLE;
            num_q       <= '0;
            pend_nota_q <= '0;
            pend_dur_q  <= '0;
            rd_addr_q   <= '0;
            rem_q       <= '0;
            nota_q      <= '0;
            fim_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            num_q       <= num_d;
            pend_nota_q <= pend_nota_d;
            pend_dur_q  <= pend_dur_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            nota_q      <= nota_d;
            fim_q       <= fim_d;
        end
    end

    memoria_eventos #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (MW)
    ) u_memoria (
        .clk_i   (clock_i),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign ctrl_if.nota_out       = nota_q;
    assign ctrl_if.nota_valida    = (estado_q == TOCA) && (nota_q != '0);
    assign ctrl_if.estado         = estado_q;
    assign ctrl_if.num_eventos    = num_q;
    assign ctrl_if.cheio          = (num_q == NUM_FULL);
    assign ctrl_if.fim_reproducao = fim_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Bench for sequenciador_notas: directed stimulus, playback stream checked by a scoreboard monitor.
// DUT a uses the default geometry, DUT b has DEPTH=4 for the buffer-full case.
module tb_sequenciador_notas;

    localparam int FIM = -1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];

    sequenciador_notas_if #(.NUM_TECLAS(13), .DEPTH(256), .TEMPO_W(4)) ifa ();
    sequenciador_notas_if #(.NUM_TECLAS(13), .DEPTH(4),   .TEMPO_W(4)) ifb ();

    sequenciador_notas #(.NUM_TECLAS(13), .DEPTH(256), .TEMPO_W(4)) dut_a (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .ctrl_if   (ifa)
    );

    sequenciador_notas #(.NUM_TECLAS(13), .DEPTH(4), .TEMPO_W(4)) dut_b (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .ctrl_if   (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string nm, input int act);
        int e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: unexpected output %0d, scoreboard empty (t=%0t)", nm, act, $time);
        end else begin
            e = exp_q.pop_front();
            chk(nm, act, e);
        end
    endtask

    // Monitor: every fim pulse and every tick seen during TOCA consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.fim_reproducao) sb_pop("fim_reproducao", FIM);
            if (ifa.tick && ifa.estado == 2'd3) sb_pop("nota_out", int'(ifa.nota_out));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_a();
        ifa.tick = 1'b1; cyc(1); ifa.tick = 1'b0; cyc(3);
    endtask

    task automatic tick_b();
        ifb.tick = 1'b1; cyc(1); ifb.tick = 1'b0; cyc(3);
    endtask

    task automatic pulse_grava();
        ifa.grava = 1'b1; cyc(1); ifa.grava = 1'b0;
    endtask

    task automatic pulse_toca();
        ifa.toca = 1'b1; cyc(1); ifa.toca = 1'b0;
    endtask

    task automatic pulse_para();
        ifa.para = 1'b1; cyc(1); ifa.para = 1'b0;
    endtask

    task automatic push_n(input int nota, input int n);
        repeat (n) exp_q.push_back(nota);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {ifa.tick, ifa.grava, ifa.toca, ifa.para, ifa.loop_en} = '0;
        {ifb.tick, ifb.grava, ifb.toca, ifb.para, ifb.loop_en} = '0;
        ifa.teclas = '0;
        ifb.teclas = '0;

        cyc(3);
        chk("rst estado", int'(ifa.estado), 0);
        chk("rst nota_out", int'(ifa.nota_out), 0);
        chk("rst nota_valida", int'(ifa.nota_valida), 0);
        chk("rst num_eventos", int'(ifa.num_eventos), 0);
        chk("rst cheio", int'(ifa.cheio), 0);
        chk("rst fim", int'(ifa.fim_reproducao), 0);
        chk("rst b cheio", int'(ifb.cheio), 0);
        rst_n = 1'b1;
        cyc(2);

        // Record: key 2 for 3 ticks, key 5 for 2 ticks -> (3,3),(6,2)
        pulse_grava();
        chk("grava estado", int'(ifa.estado), 1);
        ifa.teclas = 13'(1 << 2);
        repeat (3) tick_a();
        ifa.teclas = 13'(1 << 5) | 13'(1 << 9);
        repeat (2) tick_a();
        pulse_para();
        chk("rec num_eventos", int'(ifa.num_eventos), 2);
        chk("rec estado idle", int'(ifa.estado), 0);
        ifa.teclas = '0;

        // Playback once
        push_n(3, 3); push_n(6, 2); exp_q.push_back(FIM);
        pulse_toca();
        chk("play carrega", int'(ifa.estado), 2);
        chk("play nota before", int'(ifa.nota_out), 0);
        cyc(1);
        chk("play first nota", int'(ifa.nota_out), 3);
        chk("play valida", int'(ifa.nota_valida), 1);
        repeat (5) tick_a();
        chk("play end estado", int'(ifa.estado), 0);
        chk("play end nota", int'(ifa.nota_out), 0);

        // Loop playback: wraps only when the loop feature is built in
        ifa.loop_en = 1'b1;
`ifdef SEQUENCIADOR_LOOP_EN
        push_n(3, 3); push_n(6, 2); push_n(3, 2);
`else
        push_n(3, 3); push_n(6, 2); exp_q.push_back(FIM);
`endif
        pulse_toca();
        cyc(1);
        repeat (7) tick_a();
        pulse_para();
        chk("loop stop estado", int'(ifa.estado), 0);
        chk("loop stop nota", int'(ifa.nota_out), 0);
        ifa.loop_en = 1'b0;
        cyc(2);

        // Empty buffer: grava then para with no ticks stores nothing
        pulse_grava();
        pulse_para();
        chk("empty num", int'(ifa.num_eventos), 0);
        exp_q.push_back(FIM);
        pulse_toca();
        cyc(1);
        chk("empty toca estado", int'(ifa.estado), 0);

        // grava and toca together: grava wins
        ifa.teclas = 13'(1);
        ifa.grava = 1'b1; ifa.toca = 1'b1;
        cyc(1);
        ifa.grava = 1'b0; ifa.toca = 1'b0;
        chk("grava+toca estado", int'(ifa.estado), 1);
        repeat (2) tick_a();
        // para with a same-cycle tick: tick dropped, entry is (1,2)
        ifa.tick = 1'b1; ifa.para = 1'b1;
        cyc(1);
        ifa.tick = 1'b0; ifa.para = 1'b0;
        cyc(3);
        chk("para+tick num", int'(ifa.num_eventos), 1);
        chk("para+tick estado", int'(ifa.estado), 0);
        push_n(1, 2); exp_q.push_back(FIM);
        pulse_toca();
        cyc(1);
        repeat (2) tick_a();
        chk("para+tick play end", int'(ifa.estado), 0);

        // Duration saturation: key 0 for 20 ticks -> (1,15),(1,5)
        pulse_grava();
        repeat (20) tick_a();
        pulse_para();
        chk("sat num", int'(ifa.num_eventos), 2);
        ifa.teclas = '0;
        push_n(1, 20); exp_q.push_back(FIM);
        pulse_toca();
        cyc(1);
        repeat (20) tick_a();
        chk("sat play end", int'(ifa.estado), 0);

        // Full buffer on DUT b (DEPTH=4): alternate keys every tick
        ifb.grava = 1'b1; cyc(1); ifb.grava = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifb.teclas = 13'(1 << (k % 2));
            tick_b();
        end
        chk("full num after 4 ticks", int'(ifb.num_eventos), 3);
        chk("full estado before", int'(ifb.estado), 1);
        chk("full cheio before", int'(ifb.cheio), 0);
        ifb.teclas = 13'(1 << 0);
        tick_b();
        chk("full num", int'(ifb.num_eventos), 4);
        chk("full cheio", int'(ifb.cheio), 1);
        chk("full estado", int'(ifb.estado), 0);
        ifb.teclas = 13'(1 << 1);
        repeat (2) tick_b();
        chk("full ticks ignored", int'(ifb.num_eventos), 4);
        ifb.grava = 1'b1; cyc(1); ifb.grava = 1'b0;
        chk("full regrava num", int'(ifb.num_eventos), 0);
        chk("full regrava cheio", int'(ifb.cheio), 0);

        // Reset mid-TOCA: outputs clear without a clock edge
        push_n(1, 2);
        pulse_toca();
        cyc(1);
        repeat (2) tick_a();
        chk("pre-reset valida", int'(ifa.nota_valida), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset estado", int'(ifa.estado), 0);
        chk("areset nota", int'(ifa.nota_out), 0);
        chk("areset valida", int'(ifa.nota_valida), 0);
        chk("areset num", int'(ifa.num_eventos), 0);
        chk("areset fim", int'(ifa.fim_reproducao), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
